// File: rtl/dma_pkg.sv
// dma_pkg: shared state encoding and register offsets for the HDMA engine
package dma_pkg;

    typedef enum logic [1:0] {IDLE, RD, WR, WAIT_HB} state_t;

    localparam logic [2:0] SRC_HI = 3'd0;
    localparam logic [2:0] SRC_LO = 3'd1;
    localparam logic [2:0] DST_HI = 3'd2;
    localparam logic [2:0] DST_LO = 3'd3;
    localparam logic [2:0] CTRL   = 3'd4;

    function automatic logic [15:0] put_byte(input logic [15:0] v, input logic hi, input logic [7:0] b);
        return hi ? {b, v[7:0]} : {v[15:8], b};
    endfunction

endpackage

// File: rtl/hdma_engine.sv
// hdma_engine: block copy engine with general and per-hblank transfer modes
module hdma_engine
    import dma_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int BLK_BYTES = 16,
    parameter int CNT_W     = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_addr,
    input  logic [7:0]        cfg_wdata,
    output logic [7:0]        cfg_rdata,
    input  logic              hblank_pulse,
    output logic              mst_req,
    output logic [ADDR_W-1:0] mst_addr,
    input  logic [7:0]        mst_rdata,
    output logic [7:0]        mst_wdata,
    output logic              mst_write,
    output logic              done_irq
);

    localparam int OFF_W = $clog2(BLK_BYTES);
    localparam logic [ADDR_W-1:0] AMASK = ~ADDR_W'(BLK_BYTES - 1);

    state_t state, state_nx;
    logic [ADDR_W-1:0] src, dst;
    logic [CNT_W-1:0] cnt;
    logic [OFF_W-1:0] boff;
    logic hb_mode, hb_pend, cancel_pend;
    logic ctrl_wr, start, cancel_wr, last_step, cnt_zero, busy;
    logic [15:0] src_new, dst_new;

    assign ctrl_wr   = cfg_we && cfg_addr == CTRL;
    assign start     = ctrl_wr && state == IDLE;
    assign busy      = state == RD || state == WR;
    assign cancel_wr = ctrl_wr && !cfg_wdata[7] && hb_mode && state != IDLE;
    assign last_step = state == WR && ce && &boff;
    assign cnt_zero  = cnt == '0;
    assign src_new   = put_byte(16'(src), cfg_addr == SRC_HI, cfg_wdata);
    assign dst_new   = put_byte(16'(dst), cfg_addr == DST_HI, cfg_wdata);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state: starts and WAIT_HB cancels act on the write strobe, stepping waits for ce
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (ctrl_wr) state_nx = cfg_wdata[7] ? WAIT_HB : RD;
            WAIT_HB: state_nx = cancel_wr ? IDLE : (ce && hb_pend) ? RD : WAIT_HB;
            RD:      if (ce) state_nx = WR;
            WR:      if (ce) state_nx = !(&boff) ? RD :
                                        (cnt_zero || cancel_pend || cancel_wr) ? IDLE :
                                        hb_mode ? WAIT_HB : RD;
            default: state_nx = IDLE;
        endcase
    end

    // bus and register-read outputs decoded from the current state
    always_comb begin
        mst_req   = busy;
        mst_write = state == WR;
        mst_addr  = state == RD ? src : state == WR ? dst : '0;
        cfg_rdata = cfg_addr == CTRL ? {state == IDLE, 7'(cnt)} : 8'hFF;
    end

    // address/count registers, data latch, hblank pending flag and completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src         <= '0;
            dst         <= '0;
            cnt         <= '1;
            boff        <= '0;
            hb_mode     <= 1'b0;
            hb_pend     <= 1'b0;
            cancel_pend <= 1'b0;
            mst_wdata   <= 8'h00;
            done_irq    <= 1'b0;
        end else begin
            done_irq    <= last_step && cnt_zero;
            hb_pend     <= state == WAIT_HB && (hb_pend ? !ce : hblank_pulse);
            cancel_pend <= busy && (cancel_pend || cancel_wr);
            if (state == IDLE && cfg_we && (cfg_addr == SRC_HI || cfg_addr == SRC_LO))
                src <= ADDR_W'(src_new) & AMASK;
            if (state == IDLE && cfg_we && (cfg_addr == DST_HI || cfg_addr == DST_LO))
                dst <= ADDR_W'(dst_new) & AMASK;
            if (start) begin
                cnt     <= cfg_wdata[CNT_W-1:0];
                hb_mode <= cfg_wdata[7];
                boff    <= '0;
            end
            if (ce && state == RD)
                mst_wdata <= mst_rdata;
            if (ce && state == WR) begin
                src  <= src + 1'b1;
                dst  <= dst + 1'b1;
                boff <= boff + 1'b1;
                if (&boff) cnt <= cnt - 1'b1;
            end
        end
    end

endmodule
